// File: rtl/sram_write_port.sv
//------------------------------------------------------------------------------
// sram_write_port : buffers renderer write commands in a FIFO and replays them
//                   in order to the SRAM controller, one per done pulse.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef SRAM_ADDRESS_WIDTH
`define SRAM_ADDRESS_WIDTH 20
`endif
`ifndef SRAM_DATA_WIDTH
`define SRAM_DATA_WIDTH 16
`endif

package sram_write_port_pkg;
  typedef struct packed {
    logic [`SRAM_ADDRESS_WIDTH-1:0] address;
    logic                           oe_n;
    logic                           we_n;
    logic                           den;
    logic [`SRAM_DATA_WIDTH-1:0]    dout;
  } SramRequest_t;

  typedef struct packed {
    logic done;
  } SramResult_t;
endpackage

module sram_write_port #(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wrValid,
  output logic                                wrReady,
  input  logic [`SRAM_ADDRESS_WIDTH-1:0]      wrAddress,
  input  logic [`SRAM_DATA_WIDTH-1:0]         wrData,
  output sram_write_port_pkg::SramRequest_t   request,
  input  sram_write_port_pkg::SramResult_t    result,
  output logic                                idle,
  output logic [$clog2(DEPTH):0]              level,
  output logic [15:0]                         writeCount
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_LW = c_PW + 1;
  localparam int c_AW = `SRAM_ADDRESS_WIDTH;
  localparam int c_DW = `SRAM_DATA_WIDTH;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

  logic [c_PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [c_LW-1:0]      level_q, level_d;
  logic [15:0]          write_count_q, write_count_d;
  logic [c_AW+c_DW-1:0] mem_q [DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic [c_AW+c_DW-1:0] w_head;

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // in the same cycle as a pop.
  assign wrReady    = (level_q != c_FULL);
  assign idle       = (level_q == '0);
  assign level      = level_q;
  assign writeCount = write_count_q;

  assign w_push = wrValid && wrReady;
  assign w_pop  = result.done && (level_q != '0);
  assign w_head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    write_count_d = write_count_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PW'(1);
    end
    if (w_pop) begin
      rd_ptr_d      = rd_ptr_q + c_PW'(1);
      write_count_d = write_count_q + 16'd1;
    end
    level_d = level_q + c_LW'(w_push) - c_LW'(w_pop);
  end

  // Request is built from registered head state only; no bypass from wrData.
  always_comb begin
    request.address = '0;
    request.dout    = '0;
    request.den     = 1'b0;
    request.oe_n    = 1'b1;
    request.we_n    = 1'b1;
    if (level_q != '0) begin
      request.address = w_head[c_AW+c_DW-1:c_DW];
      request.dout    = w_head[c_DW-1:0];
      request.den     = 1'b1;
      request.we_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      write_count_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      write_count_q <= write_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {wrAddress, wrData};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_write_port.sv
//------------------------------------------------------------------------------
// tb_sram_write_port : directed self-checking bench for sram_write_port.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_write_port;
  import sram_write_port_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wrValid = 1'b0;
  logic         wrReady;
  logic [19:0]  wrAddress = '0;
  logic [15:0]  wrData = '0;
  SramRequest_t request;
  SramResult_t  result;
  logic         idle;
  logic [2:0]   level;
  logic [15:0]  writeCount;

  int total = 0;
  int bad   = 0;
  int idx;
  logic [35:0] cap_q[$];
  logic [35:0] ent;

  sram_write_port #(.DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrAddress  (wrAddress),
    .wrData     (wrData),
    .request    (request),
    .result     (result),
    .idle       (idle),
    .level      (level),
    .writeCount (writeCount)
  );

  always #20 clk = ~clk;

  // SRAM model: record every word the controller actually writes.
  always @(posedge clk) begin
    if (rst && result.done && !request.we_n) begin
      cap_q.push_back({request.address, request.dout});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_req(input string tag);
    check({tag, "_we_n"}, 32'(request.we_n), 32'd1);
    check({tag, "_oe_n"}, 32'(request.oe_n), 32'd1);
    check({tag, "_den"},  32'(request.den),  32'd0);
    check({tag, "_addr"}, 32'(request.address), 32'd0);
    check({tag, "_dout"}, 32'(request.dout), 32'd0);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    result.done = 1'b0;

    // Reset state
    tick();
    check("rst_rdy",   32'(wrReady), 32'd1);
    check("rst_idle",  32'(idle), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wcnt",  32'(writeCount), 32'd0);
    check_idle_req("rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single write
    wrValid = 1'b1; wrAddress = 20'h00010; wrData = 16'hBEEF;
    #1;
    check("nobypass_we_n", 32'(request.we_n), 32'd1);
    tick();
    wrValid = 1'b0;
    check("sw_level", 32'(level), 32'd1);
    check("sw_we_n",  32'(request.we_n), 32'd0);
    check("sw_den",   32'(request.den), 32'd1);
    check("sw_oe_n",  32'(request.oe_n), 32'd1);
    check("sw_addr",  32'(request.address), 32'h00010);
    check("sw_dout",  32'(request.dout), 32'hBEEF);
    result.done = 1'b1;
    tick();
    result.done = 1'b0;
    check("sw_idle", 32'(idle), 32'd1);
    check("sw_wcnt", 32'(writeCount), 32'd1);

    // Fill to DEPTH with done held low; fifth command is held off
    for (int i = 0; i < 5; i++) begin
      wrValid = 1'b1; wrAddress = 20'h00100 + 20'(i); wrData = 16'h1000 + 16'(i);
      #1;
      check("fill_rdy", 32'(wrReady), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    check("fill_level", 32'(level), 32'd4);
    check("fill_head",  32'(request.address), 32'h00100);
    tick();
    check("held_level", 32'(level), 32'd4);
    check("held_head",  32'(request.dout), 32'h1000);
    result.done = 1'b1;
    #1;
    check("full_pop_rdy", 32'(wrReady), 32'd0);
    tick();
    result.done = 1'b0;
    check("after_pop_level", 32'(level), 32'd3);
    check("after_pop_rdy",   32'(wrReady), 32'd1);
    tick();
    wrValid = 1'b0;
    check("fifth_level", 32'(level), 32'd4);
    check("fifth_head",  32'(request.address), 32'h00101);
    result.done = 1'b1;
    repeat (4) tick();
    result.done = 1'b0;
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_wcnt", 32'(writeCount), 32'd6);

    // Ordering under alternating done
    cap_q.delete();
    idx = 0;
    for (int c = 0; c < 200 && !(idx == 8 && idle); c++) begin
      wrValid     = (idx < 8);
      wrAddress   = 20'h20000 + 20'(idx * 32'h111);
      wrData      = 16'hA000 + 16'(idx);
      result.done = c[0];
      #1;
      if (wrValid && wrReady) idx++;
      tick();
    end
    wrValid = 1'b0;
    result.done = 1'b0;
    check("ord_count", 32'(cap_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      ent = (i < cap_q.size()) ? cap_q[i] : 36'hF_FFFF_FFFF;
      check("ord_addr", 32'(ent[35:16]), 32'h20000 + 32'(i * 32'h111));
      check("ord_data", 32'(ent[15:0]),  32'hA000 + 32'(i));
    end
    check("ord_wcnt", 32'(writeCount), 32'd14);

    // Simultaneous push and pop at level 2
    wrValid = 1'b1; wrAddress = 20'h00300; wrData = 16'h3000;
    tick();
    wrAddress = 20'h00301; wrData = 16'h3001;
    tick();
    check("sim_pre_level", 32'(level), 32'd2);
    check("sim_pre_head",  32'(request.address), 32'h00300);
    wrAddress = 20'h00302; wrData = 16'h3002; result.done = 1'b1;
    tick();
    wrValid = 1'b0;
    check("sim_level", 32'(level), 32'd2);
    check("sim_addr",  32'(request.address), 32'h00301);
    check("sim_dout",  32'(request.dout), 32'h3001);
    tick();
    check("sim_next", 32'(request.address), 32'h00302);
    tick();
    result.done = 1'b0;
    check("sim_wcnt", 32'(writeCount), 32'd17);

    // Spurious done while empty
    result.done = 1'b1;
    repeat (3) tick();
    check("spur_idle",  32'(idle), 32'd1);
    check("spur_level", 32'(level), 32'd0);
    check("spur_wcnt",  32'(writeCount), 32'd17);
    check_idle_req("spur");
    result.done = 1'b0;

    // Reset mid-burst at level 3
    wrValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wrAddress = 20'h00400 + 20'(i); wrData = 16'h4000 + 16'(i);
      tick();
    end
    wrValid = 1'b0;
    check("mid_level", 32'(level), 32'd3);
    #5;
    rst = 1'b0;
    #1;
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_rdy",   32'(wrReady), 32'd1);
    check("mrst_idle",  32'(idle), 32'd1);
    check("mrst_wcnt",  32'(writeCount), 32'd0);
    check_idle_req("mrst");
    @(negedge clk);
    rst = 1'b1;
    result.done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we_n", 32'(request.we_n), 32'd1);
    end
    result.done = 1'b0;

    // writeCount wrap: stream 65536 writes from zero
    wrValid = 1'b1; wrAddress = 20'h00500; wrData = 16'h5555; result.done = 1'b1;
    repeat (65536) tick();
    check("wrap_pre", 32'(writeCount), 32'hFFFF);
    check("wrap_lvl", 32'(level), 32'd1);
    wrValid = 1'b0;
    tick();
    result.done = 1'b0;
    check("wrap_zero", 32'(writeCount), 32'h0000);
    check("wrap_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_write_port.md
SRAM_WRITE_PORT -- requirements
Module: sram_write_port

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered write-command entries; legal values are powers of two, 2..16.
REQ-002 clk  input  1  system clock, 25 MHz, the same clock as the SRAM controller.
REQ-003 rst  input  1  reset; one clock; reset SHALL be asynchronous and active-low.
REQ-004 wrValid  input  1  a renderer write command is present.
REQ-005 wrReady  output  1  the port accepts the command this cycle.
REQ-006 wrAddress  input  `SRAM_ADDRESS_WIDTH  target SRAM word address.
REQ-007 wrData  input  `SRAM_DATA_WIDTH  word to write.
REQ-008 request  output  SramRequest_t  request to the controller's renderer input (address, oe_n, we_n, den, dout).
REQ-009 result  input  SramResult_t  result from the controller's renderer output; only the done field is used.
REQ-010 idle  output  1  buffer is empty.
REQ-011 level  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 writeCount  output  16  count of completed SRAM writes.

Function
REQ-013 The port SHALL hold commands in a circular FIFO of DEPTH entries, each {address, data}, with read pointer, write pointer and occupancy count.
REQ-014 wrReady SHALL equal (level != DEPTH); this is combinational from registered state only and does not depend on wrValid or result.done.
REQ-015 A push SHALL occur on any rising clk edge with wrValid && wrReady; the entry is stored at the write pointer, and the pointer advances modulo DEPTH.
REQ-016 When level == 0, request SHALL be idle: address=0, dout=0, den=0, oe_n=1, we_n=1.
REQ-017 When level > 0, request SHALL present the FIFO head combinationally: address=head.address, dout=head.data, den=1, oe_n=1, we_n=0.
REQ-018 A pop SHALL occur on any rising clk edge with result.done && level > 0; the read pointer advances modulo DEPTH, and writeCount increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-019 result.done while level == 0 SHALL be ignored: no pointer change and no count change.
REQ-020 Simultaneous push and pop SHALL leave level unchanged and perform both operations.
REQ-021 When level == DEPTH and a pop occurs, wrReady remains 0 in that cycle; the push SHALL be accepted no earlier than the next cycle.
REQ-022 A pushed entry SHALL become the head no earlier than the cycle after the push; there is no combinational bypass from wrAddress/wrData to request.
REQ-023 The head entry SHALL stay stable on request for every cycle until it is popped, regardless of how many non-done cycles pass.
REQ-024 Commands SHALL be written to SRAM in acceptance order; throughput is at most one write per done pulse, i.e. one per two clocks under the alternating controller.
REQ-025 idle SHALL equal (level == 0).
REQ-026 Pointers SHALL be $clog2(DEPTH) bits with natural wrap; level is derived from a separate counter, not from pointer difference.

Reset
REQ-027 While rst is low, the pointers, level and writeCount SHALL be 0, so that wrReady=1, idle=1 and request is idle as in REQ-016.
REQ-028 FIFO data storage need not be reset.
REQ-029 Reset asserted mid-operation SHALL discard all buffered commands immediately and asynchronously; request SHALL become idle in the same cycle, with no partial write driven afterwards.

Verification
REQ-030 Single write: push {0x00010, 0xBEEF}; next cycle request shows we_n=0, den=1, address 0x00010, dout 0xBEEF; done pulse -> idle=1, writeCount=1.
REQ-031 Fill: DEPTH=4, hold done=0, push 5 commands -> the 4th is accepted, wrReady=0 after it, level=4, the 5th is held off; one done pulse -> the 5th is accepted on the following cycle.
REQ-032 Ordering under alternation: done toggles every other cycle, push A..H back-to-back -> SRAM model contents match A..H addresses/data in order, writeCount=8.
REQ-033 Simultaneous push and pop at level=2 -> level stays 2, and the head advances to the next entry.
REQ-034 Spurious done: done pulses with empty FIFO -> request remains idle, writeCount unchanged; writeCount preset near wrap: 0xFFFF + 1 write -> 0x0000.
REQ-035 Reset mid-burst with level=3 -> request is idle immediately, level=0, wrReady=1, and no further we_n=0 until a new push.
